// File: rtl/pu_mem_loader.sv
// rtl/pu_mem_loader.sv - command/stream to column-parallel PU memory bus bridge
// Writes stream straight onto the bus; reads are credit-limited into a fall-through readback FIFO.
module pu_mem_loader #(
  parameter int logNumPe          = 3,
  parameter int memDataLen        = 16,
  parameter int logMemNamespaces  = 2,
  parameter int numPuMemColumns   = 2,
  parameter int logNumPeMemColumn = 2,
  parameter int beatCountLen      = 16,
  parameter int rdLatency         = 2,
  parameter int logRdFifoDepth    = 2
) (
  input  logic                                               clk,
  input  logic                                               reset,
  input  logic                                               cmd_valid,
  output logic                                               cmd_ready,
  input  logic                                               cmd_rd_wrt,
  input  logic [logMemNamespaces-1:0]                        cmd_data_type,
  input  logic [beatCountLen-1:0]                            cmd_beats,
  input  logic [memDataLen*numPuMemColumns-1:0]              wr_data,
  input  logic                                               wr_valid,
  output logic                                               wr_ready,
  output logic [memDataLen*numPuMemColumns-1:0]              rd_data,
  output logic                                               rd_valid,
  input  logic                                               rd_ready,
  output logic                                               busy,
  output logic                                               done,
  output logic [(logNumPeMemColumn+1)*numPuMemColumns-1:0]   ctrl_mem_out,
  output logic                                               mem_rd_wrt,
  output logic [logMemNamespaces-1:0]                        mem_data_type,
  output logic [memDataLen*numPuMemColumns-1:0]              mem_data_out,
  input  logic [memDataLen*numPuMemColumns-1:0]              mem_data_in
);

  localparam int BUSW  = memDataLen * numPuMemColumns;
  localparam int DEPTH = 1 << logRdFifoDepth;
  localparam int CNTW  = logRdFifoDepth + 2;

  if ((numPuMemColumns << logNumPeMemColumn) != (1 << logNumPe)) begin : g_bad_cfg
    $error("pu_mem_loader: column count and peId width do not cover the PE array");
  end

  typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;
  state_t state, state_next;

  logic [beatCountLen-1:0]       beats_left;
  logic [logNumPeMemColumn-1:0]  pe_ptr;
  logic                          bus_rd_vld;
  logic [rdLatency-1:0]          rd_pipe;
  logic [BUSW-1:0]               fifo_mem [DEPTH];
  logic [logRdFifoDepth-1:0]     fifo_wp, fifo_rp;
  logic [logRdFifoDepth:0]       fifo_count;
  logic [CNTW-1:0]               in_flight;
  logic accept, wr_beat, rd_beat, beat, last_beat, capture, pop, credit_ok, done_next;

  // Outstanding reads: the beat currently on the bus plus every latency stage behind it.
  always_comb begin
    in_flight = CNTW'(bus_rd_vld);
    for (int i = 0; i < rdLatency; i++) in_flight = in_flight + CNTW'(rd_pipe[i]);
  end

  assign capture   = rd_pipe[rdLatency-1];
  assign pop       = rd_ready && (fifo_count != '0);
  assign credit_ok = (CNTW'(fifo_count) + in_flight) < CNTW'(DEPTH);
  assign last_beat = (beats_left == beatCountLen'(1));
  assign beat      = wr_beat || rd_beat;

  assign cmd_ready = (state == IDLE);
  assign wr_ready  = (state == WRITE);
  assign busy      = (state != IDLE);
  assign rd_valid  = (fifo_count != '0);
  assign rd_data   = rd_valid ? fifo_mem[fifo_rp] : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    wr_beat    = 1'b0;
    rd_beat    = 1'b0;
    done_next  = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          accept = 1'b1;
          if (cmd_beats == '0) done_next = 1'b1;
          else                 state_next = cmd_rd_wrt ? READ : WRITE;
        end
      end
      WRITE: begin
        if (wr_valid) begin
          wr_beat = 1'b1;
          if (last_beat) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end
        end
      end
      READ: begin
        if (credit_ok) begin
          rd_beat = 1'b1;
          if (last_beat) state_next = DRAIN;
        end
      end
      DRAIN: begin
        // All beats issued, so the return with nothing behind it is the last one.
        if (capture && in_flight == CNTW'(1)) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      beats_left    <= '0;
      pe_ptr        <= '0;
      mem_rd_wrt    <= 1'b0;
      mem_data_type <= '0;
      mem_data_out  <= '0;
      ctrl_mem_out  <= '0;
      bus_rd_vld    <= 1'b0;
      rd_pipe       <= '0;
      done          <= 1'b0;
    end else begin
      if (accept) begin
        mem_rd_wrt    <= cmd_rd_wrt;
        mem_data_type <= cmd_data_type;
        beats_left    <= cmd_beats;
        pe_ptr        <= '0;
      end else if (beat) begin
        beats_left <= beats_left - beatCountLen'(1);
        pe_ptr     <= pe_ptr + logNumPeMemColumn'(1);
      end
      ctrl_mem_out <= beat ? {numPuMemColumns{pe_ptr, 1'b1}} : '0;
      if (wr_beat) mem_data_out <= wr_data;
      bus_rd_vld <= rd_beat;
      rd_pipe[0] <= bus_rd_vld;
      for (int i = 1; i < rdLatency; i++) rd_pipe[i] <= rd_pipe[i-1];
      done <= done_next;
    end
  end

  always_ff @(posedge clk) begin
    if (capture) fifo_mem[fifo_wp] <= mem_data_in;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fifo_wp    <= '0;
      fifo_rp    <= '0;
      fifo_count <= '0;
    end else begin
      if (capture) fifo_wp <= fifo_wp + logRdFifoDepth'(1);
      if (pop)     fifo_rp <= fifo_rp + logRdFifoDepth'(1);
      case ({capture, pop})
        2'b10:   fifo_count <= fifo_count + (logRdFifoDepth+1)'(1);
        2'b01:   fifo_count <= fifo_count - (logRdFifoDepth+1)'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

endmodule

// File: tb/tb_pu_mem_loader.sv
// tb/tb_pu_mem_loader.sv - self-checking bench for pu_mem_loader
// A behavioural PU memory answers reads two cycles after each bus beat.
module tb_pu_mem_loader;
  localparam int DEPTH = 4;
  localparam int RDLAT = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_rd_wrt, wr_valid, rd_ready;
  logic [1:0]  cmd_data_type;
  logic [15:0] cmd_beats;
  logic [31:0] wr_data, mem_data_in;
  logic        cmd_ready, wr_ready, rd_valid, busy, done, mem_rd_wrt;
  logic [31:0] rd_data, mem_data_out;
  logic [5:0]  ctrl_mem_out;
  logic [1:0]  mem_data_type;

  int checks = 0;
  int failures = 0;

  pu_mem_loader dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_rd_wrt(cmd_rd_wrt), .cmd_data_type(cmd_data_type), .cmd_beats(cmd_beats),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .busy(busy), .done(done), .ctrl_mem_out(ctrl_mem_out), .mem_rd_wrt(mem_rd_wrt),
    .mem_data_type(mem_data_type), .mem_data_out(mem_data_out), .mem_data_in(mem_data_in)
  );

  always #5 clk = ~clk;

  // PU model: word for a given namespace/column/peId
  function automatic logic [15:0] pu_word(input int t, input int col, input int pe);
    return 16'(col * 'h100 + pe + t * 'h1000);
  endfunction

  function automatic logic [5:0] exp_ctrl(input int pe);
    logic [5:0] r;
    for (int j = 0; j < 2; j++) begin
      r[3*j] = 1'b1;
      r[3*j+1 +: 2] = 2'(pe % 4);
    end
    return r;
  endfunction

  logic [5:0]  bus_d1, bus_d2;
  logic [31:0] noise;
  always @(posedge clk) begin
    bus_d2 <= bus_d1;
    bus_d1 <= ctrl_mem_out;
    noise  <= $urandom;
  end
  always_comb begin
    mem_data_in = noise;
    for (int j = 0; j < 2; j++)
      if (bus_d2[3*j]) mem_data_in[16*j +: 16] = pu_word(int'(mem_data_type), j, int'(bus_d2[3*j+1 +: 2]));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic rd, input logic [1:0] t, input int n);
    cmd_valid = 1'b1; cmd_rd_wrt = rd; cmd_data_type = t; cmd_beats = 16'(n);
    checks++;
    if (cmd_ready !== 1'b1) begin failures++; $display("FAIL cmd_ready: got %b want 1", cmd_ready); end
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; cmd_valid = 0; cmd_rd_wrt = 0; cmd_data_type = 0; cmd_beats = 0;
    wr_data = 0; wr_valid = 0; rd_ready = 0;
    tick(); tick();
    checks++;
    if ({cmd_ready, wr_ready, rd_valid, busy, done, mem_rd_wrt} !== 6'b100000) begin
      failures++; $display("FAIL reset_flags: got %b want 100000", {cmd_ready, wr_ready, rd_valid, busy, done, mem_rd_wrt});
    end
    checks++;
    if ({ctrl_mem_out, mem_data_type, mem_data_out, rd_data} !== '0) begin
      failures++; $display("FAIL reset_buses: ctrl=%h type=%h out=%h rd=%h want 0", ctrl_mem_out, mem_data_type, mem_data_out, rd_data);
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic run_write(input logic [1:0] t, input int n, input int pat, input bit spec_data);
    int k = 0, cyc = 0;
    logic [31:0] d;
    logic v;
    send_cmd(1'b0, t, n);
    checks++;
    if (mem_rd_wrt !== 1'b0 || mem_data_type !== t) begin
      failures++; $display("FAIL wr_mode: rd_wrt=%b type=%0d want 0/%0d", mem_rd_wrt, mem_data_type, t);
    end
    while (k < n && cyc < 2000) begin
      v = (pat == 0) ? 1'b1 : (pat == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
      d = spec_data ? {16'(k + 16), 16'(k)} : $urandom;
      wr_valid = v; wr_data = d;
      checks++;
      if (wr_ready !== 1'b1) begin failures++; $display("FAIL wr_ready: got %b want 1", wr_ready); end
      tick();
      if (v) begin
        checks++;
        if (ctrl_mem_out !== exp_ctrl(k) || mem_data_out !== d) begin
          failures++; $display("FAIL wr_beat%0d: ctrl=%h data=%h want %h/%h", k, ctrl_mem_out, mem_data_out, exp_ctrl(k), d);
        end
        checks++;
        if (done !== (k == n - 1)) begin failures++; $display("FAIL wr_done%0d: got %b want %b", k, done, k == n - 1); end
        k++;
      end else begin
        checks++;
        if (ctrl_mem_out !== 6'h0 || done !== 1'b0) begin
          failures++; $display("FAIL wr_gap: ctrl=%h done=%b want 0/0", ctrl_mem_out, done);
        end
      end
      cyc++;
    end
    wr_valid = 1'b0;
    checks++;
    if (k != n) begin failures++; $display("FAIL wr_timeout: beats %0d want %0d", k, n); end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || ctrl_mem_out !== 6'h0) begin
      failures++; $display("FAIL wr_end: done=%b busy=%b ctrl=%h want 0", done, busy, ctrl_mem_out);
    end
  endtask

  // hold: cycles with rd_ready low before it rises; rnd: random rd_ready afterwards
  task automatic run_read(input logic [1:0] t, input int n, input int hold, input bit rnd);
    logic [31:0] expq[$];
    int issued = 0, popped = 0, done_cnt = 0, c = 0, last_bus = -100, first_bus = -1, first_rv = -1;
    send_cmd(1'b1, t, n);
    checks++;
    if (mem_rd_wrt !== 1'b1 || mem_data_type !== t) begin
      failures++; $display("FAIL rd_mode: rd_wrt=%b type=%0d want 1/%0d", mem_rd_wrt, mem_data_type, t);
    end
    while (!(popped == n && done_cnt == 1 && !busy) && c < 3000) begin
      if (ctrl_mem_out[0]) begin
        checks++;
        if (ctrl_mem_out !== exp_ctrl(issued) || issued >= n) begin
          failures++; $display("FAIL rd_beat%0d: ctrl=%h want %h", issued, ctrl_mem_out, exp_ctrl(issued));
        end
        expq.push_back({pu_word(t, 1, issued % 4), pu_word(t, 0, issued % 4)});
        if (first_bus < 0) first_bus = c;
        issued++;
        if (issued == n) last_bus = c;
      end else if (ctrl_mem_out !== 6'h0) begin
        checks++; failures++; $display("FAIL rd_ctrl: got %h want 0", ctrl_mem_out);
      end
      if (issued - popped > DEPTH) begin
        checks++; failures++; $display("FAIL rd_credit: outstanding %0d want <=%0d", issued - popped, DEPTH);
      end
      if (done) begin
        done_cnt++;
        checks++;
        if (c != last_bus + RDLAT + 1) begin failures++; $display("FAIL rd_done_time: cycle %0d want %0d", c, last_bus + RDLAT + 1); end
      end
      if (rd_valid && first_rv < 0) begin
        first_rv = c;
        checks++;
        if (first_rv != first_bus + RDLAT + 1) begin failures++; $display("FAIL rd_latency: cycle %0d want %0d", first_rv, first_bus + RDLAT + 1); end
      end
      if (hold > 0 && c == hold) begin
        checks++;
        if (issued != DEPTH || rd_valid !== 1'b1) begin
          failures++; $display("FAIL rd_backpressure: issued=%0d rd_valid=%b want %0d/1", issued, rd_valid, DEPTH);
        end
      end
      rd_ready = (c < hold) ? 1'b0 : rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rd_ready && rd_valid) begin
        checks++;
        if (expq.size() == 0) begin
          failures++; $display("FAIL rd_extra: got %h want none", rd_data);
        end else begin
          if (rd_data !== expq[0]) begin failures++; $display("FAIL rd_data%0d: got %h want %h", popped, rd_data, expq[0]); end
          void'(expq.pop_front());
        end
        popped++;
      end
      tick();
      c++;
    end
    rd_ready = 1'b0;
    checks++;
    if (popped != n || done_cnt != 1 || issued != n) begin
      failures++; $display("FAIL rd_total: popped=%0d issued=%0d done=%0d want %0d/%0d/1", popped, issued, done_cnt, n, n);
    end
    tick();
    checks++;
    if (rd_valid !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL rd_end: rd_valid=%b done=%b want 0", rd_valid, done); end
  endtask

  task automatic test_zero_beats();
    send_cmd(1'($urandom_range(0, 1)), 2'd2, 0);
    checks++;
    if (done !== 1'b1 || cmd_ready !== 1'b1 || busy !== 1'b0 || ctrl_mem_out !== 6'h0) begin
      failures++; $display("FAIL zero_beats: done=%b ready=%b busy=%b ctrl=%h want 1/1/0/0", done, cmd_ready, busy, ctrl_mem_out);
    end
    tick();
    checks++;
    if (done !== 1'b0 || ctrl_mem_out !== 6'h0) begin failures++; $display("FAIL zero_beats_after: done=%b ctrl=%h want 0", done, ctrl_mem_out); end
  endtask

  task automatic test_reset_mid_read();
    int seen = 0, c = 0;
    send_cmd(1'b1, 2'd1, 8);
    rd_ready = 1'b0;
    while (seen < 2 && c < 50) begin
      tick();
      if (ctrl_mem_out[0]) seen++;
      c++;
    end
    checks++;
    if (seen != 2) begin failures++; $display("FAIL mid_read_setup: beats %0d want 2", seen); end
    reset = 1'b0;
    #1;
    checks++;
    if ({wr_ready, rd_valid, busy, done, mem_rd_wrt} !== 5'b0 || {ctrl_mem_out, mem_data_type, mem_data_out, rd_data} !== '0) begin
      failures++; $display("FAIL mid_reset_outputs: flags=%b ctrl=%h rd=%h want 0", {wr_ready, rd_valid, busy, done, mem_rd_wrt}, ctrl_mem_out, rd_data);
    end
    tick(); tick();
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (rd_valid !== 1'b0 || done !== 1'b0 || cmd_ready !== 1'b1) begin
        failures++; $display("FAIL post_reset%0d: rd_valid=%b done=%b ready=%b want 0/0/1", i, rd_valid, done, cmd_ready);
      end
    end
    run_write(2'd3, 5, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      if ($urandom_range(0, 1) == 1) run_read(2'($urandom_range(0, 3)), $urandom_range(1, 12), 0, 1'b1);
      else                          run_write(2'($urandom_range(0, 3)), $urandom_range(1, 12), 2, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    run_write(2'd1, 8, 0, 1'b1);
    run_write(2'd0, 4, 1, 1'b0);
    run_read(2'd0, 4, 0, 1'b0);
    run_read(2'd2, 16, 20, 1'b0);
    test_zero_beats();
    test_reset_mid_read();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
